// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and the word type.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef logic [ALU_WIDTH-1:0] word_t;

endpackage : alu_pkg

// File: rtl/and_bit.sv
// Single-bit AND cell; one per result lane.
module and_bit (
  input  logic a,
  input  logic b,
  output logic z
);

  // Plain AND: a 0 on either input forces 0 even if the other is X/Z.
  assign z = a & b;

endmodule : and_bit

// File: rtl/and_bits.sv
// Registered bitwise AND, RZ = RA & RB, one cycle of latency.
// Async active-high clear forces the result register to zero.
module and_bits
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  output logic [WIDTH-1:0] RZ
);

  logic [WIDTH-1:0] and_w;

  // One independent cell per bit; no interaction between lanes.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    and_bit u_and_bit (
      .a (RA[i]),
      .b (RB[i]),
      .z (and_w[i])
    );
  end

  // Result register: cleared asynchronously, otherwise loads every edge.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) RZ <= '0;
    else       RZ <= and_w;
  end

endmodule : and_bits

// File: tb/tb_and_bits.sv
// Self-checking bench for and_bits: directed literal checks plus a
// behavioural model compared on every falling clock edge.
module tb_and_bits;

  localparam int W = 32;

  logic         clock = 1'b1;
  logic         clear;
  logic [W-1:0] RA, RB;
  logic [W-1:0] RZ;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  and_bits #(.WIDTH(W)) dut (
    .clock (clock),
    .clear (clear),
    .RA    (RA),
    .RB    (RB),
    .RZ    (RZ)
  );

  // Rising edges at 10, 20, 30 ns ...; falling edges mid-cycle.
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: RZ=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the result is whatever AND the operands had at the last
  // rising edge, unless clear has been seen since then.
  logic [W-1:0] model_rz = '0;
  always @(posedge clock or posedge clear) begin
    if (clear) model_rz = '0;
    else       model_rz = RA & RB;
  end

  // Continuous compare, away from the active edge.
  always @(negedge clock) begin
    if (cmp_en) chk("model", RZ, clear ? '0 : model_rz);
  end

  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input string name);
    RA = a;
    RB = b;
    @(posedge clock);
    #1 chk(name, RZ, exp);
  endtask

  initial begin
    clear = 1'b1;
    RA    = '0;
    RB    = '0;
    #1  chk("reset_t0", RZ, 32'h0000_0000);
    #14 clear = 1'b0;                       // t = 15, mid-cycle
    #1  chk("release_hold", RZ, 32'h0000_0000);
    cmp_en = 1'b1;

    apply(32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, "all_ones_and_zero");

    // Operands change before the edge; RZ must not move yet.
    RA = 32'h1234_5678;
    RB = 32'h8765_4321;
    #2 chk("no_change_before_edge", RZ, 32'h0000_0000);
    apply(32'h1234_5678, 32'h8765_4321, 32'h0224_4220, "mixed_pattern");

    apply(32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, "disjoint_nibbles");
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "all_ones");

    // Mid-cycle clear pulse: zero without an edge, reload after release.
    #2 clear = 1'b1;
    #1 chk("clear_async", RZ, 32'h0000_0000);
    clear = 1'b0;
    #2 chk("clear_released_hold", RZ, 32'h0000_0000);
    @(posedge clock);
    #1 chk("reload_after_clear", RZ, 32'hFFFF_FFFF);

    apply(32'hA5A5_A5A5, 32'h3C3C_3C3C, 32'h2424_2424, "checker_mix");

    // Back-to-back random operands; the compare process checks each cycle.
    for (int i = 0; i < 100; i++) begin
      RA = $urandom;
      RB = $urandom;
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    #1 cmp_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_and_bits
